multireceive: RTL and testbench

- Receiving end of the 3-data-line plus strobe link that `multisend`/`sender` drive toward the external controller (ardu0..2, arduControl).
- Samples and deglitches the asynchronous lines, then assembles 3-bit symbols MSB-first into a 32-bit word.
- Closes a frame after a strobe-idle timeout and presents the word with a one-cycle valid pulse.
- Used on the second board of the keylock link and in loopback test of the sender path.

---
 rtl/multireceive_pkg.sv | 16 +
 rtl/multireceive_if.sv | 24 ++
 rtl/multireceive_line_sync.sv | 25 ++
 rtl/multireceive.sv | 141 ++++++++++++++
 tb/tb_multireceive.sv | 215 +++++++++++++++++++++
 5 files changed

// File: rtl/multireceive_pkg.sv
// Link constants and receiver state encoding shared by multireceive and multisend.
package multireceive_pkg;

  localparam int unsigned SymW          = 3;
  localparam int unsigned MaxSyms       = 11;
  localparam int unsigned IdleCyclesDef = 240000;
  localparam int unsigned SyncStagesDef = 2;
  localparam int unsigned MinHighDef    = 4;

  typedef enum logic [1:0] {
    StIdle,
    StRecv,
    StDone
  } rx_state_e;

endpackage

// File: rtl/multireceive_if.sv
// Link lines from the sender plus the receiver's frame result outputs.
interface multireceive_if;

  logic        in0;
  logic        in1;
  logic        in2;
  logic        controlIn;
  logic [31:0] value;
  logic [3:0]  symCount;
  logic        valid;
  logic        overflow;
  logic        busy;

  modport master (
    output in0, in1, in2, controlIn,
    input  value, symCount, valid, overflow, busy
  );

  modport slave (
    input  in0, in1, in2, controlIn,
    output value, symCount, valid, overflow, busy
  );

endinterface

// File: rtl/multireceive_line_sync.sv
// N-stage flop synchronizer over a bus of independent asynchronous lines.
module line_sync #(
  parameter int unsigned Width  = 4,
  parameter int unsigned Stages = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [Width-1:0] d,
  output logic [Width-1:0] q
);

  logic [Width-1:0] stage_q [Stages];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < int'(Stages); i++) stage_q[i] <= '0;
    end else begin
      stage_q[0] <= d;
      for (int i = 1; i < int'(Stages); i++) stage_q[i] <= stage_q[i-1];
    end
  end

  assign q = stage_q[Stages-1];

endmodule

// File: rtl/multireceive.sv
// Receiver for the 3-data-line + strobe link: deglitches strobes, assembles
// 3-bit symbols MSB-first and closes a frame after a strobe-idle timeout.
module multireceive
  import multireceive_pkg::*;
#(
  parameter int unsigned SYNC_STAGES = SyncStagesDef,
  parameter int unsigned MIN_HIGH    = MinHighDef,
  parameter int unsigned IDLE_CYCLES = IdleCyclesDef,
  parameter int unsigned MAX_SYMS    = MaxSyms
) (
  input  logic           hwclk,
  input  logic           resetN,
  multireceive_if.slave  bus
);

  localparam int unsigned HiW   = $clog2(MIN_HIGH + 1);
  localparam int unsigned IdleW = (IDLE_CYCLES > 2) ? $clog2(IDLE_CYCLES) : 1;

  localparam logic [HiW-1:0]   HiMax     = HiW'(MIN_HIGH);
  localparam logic [HiW-1:0]   HiAccept  = HiW'(MIN_HIGH - 1);
  localparam logic [IdleW-1:0] IdleLast  = IdleW'(IDLE_CYCLES - 1);
  localparam logic [3:0]       MaxSymsW  = 4'(MAX_SYMS);

  logic [3:0]      raw, synced;
  logic            strobe;
  logic [SymW-1:0] sym;
  logic            accept;

  assign raw = {bus.controlIn, bus.in2, bus.in1, bus.in0};

  line_sync #(
    .Width  (4),
    .Stages (SYNC_STAGES)
  ) u_line_sync (
    .clk   (hwclk),
    .rst_n (resetN),
    .d     (raw),
    .q     (synced)
  );

  assign strobe = synced[3];
  assign sym    = synced[SymW-1:0];

  logic [HiW-1:0] hi_cnt_q, hi_cnt_d;

  // Saturating high-run counter: accept fires once, on the cycle it reaches MIN_HIGH.
  always_comb begin
    hi_cnt_d = hi_cnt_q;
    if (!strobe)                hi_cnt_d = '0;
    else if (hi_cnt_q != HiMax) hi_cnt_d = hi_cnt_q + 1'b1;
  end

  assign accept = strobe && (hi_cnt_q == HiAccept);

  rx_state_e        state_q, state_d;
  logic [31:0]      shift_q, shift_d;
  logic [3:0]       nsyms_q, nsyms_d;
  logic [IdleW-1:0] idle_q, idle_d;
  logic [31:0]      value_q, value_d;
  logic [3:0]       count_q, count_d;
  logic             valid_q, valid_d;
  logic             ovf_q, ovf_d;

  always_comb begin
    state_d = state_q;
    shift_d = shift_q;
    nsyms_d = nsyms_q;
    idle_d  = idle_q;
    value_d = value_q;
    count_d = count_q;
    valid_d = 1'b0;
    ovf_d   = ovf_q;
    unique case (state_q)
      StIdle: begin
        if (accept) begin
          state_d = StRecv;
          shift_d = {{(32-SymW){1'b0}}, sym};
          nsyms_d = 4'd1;
          idle_d  = '0;
        end
      end
      StRecv: begin
        if (strobe) begin
          idle_d = '0;
          if (accept) begin
            // Bits past 32 fall off the top; overflow is judged from nsyms at DONE.
            shift_d = {shift_q[31-SymW:0], sym};
            if (nsyms_q != 4'hf) nsyms_d = nsyms_q + 4'd1;
          end
        end else if (idle_q == IdleLast) begin
          state_d = StDone;
        end else begin
          idle_d = idle_q + 1'b1;
        end
      end
      StDone: begin
        state_d = StIdle;
        if (nsyms_q <= MaxSymsW) begin
          value_d = shift_q;
          count_d = nsyms_q;
          valid_d = 1'b1;
          ovf_d   = 1'b0;
        end else begin
          ovf_d   = 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge hwclk) begin
    if (!resetN) begin
      hi_cnt_q <= '0;
      state_q  <= StIdle;
      shift_q  <= '0;
      nsyms_q  <= '0;
      idle_q   <= '0;
      value_q  <= '0;
      count_q  <= '0;
      valid_q  <= 1'b0;
      ovf_q    <= 1'b0;
    end else begin
      hi_cnt_q <= hi_cnt_d;
      state_q  <= state_d;
      shift_q  <= shift_d;
      nsyms_q  <= nsyms_d;
      idle_q   <= idle_d;
      value_q  <= value_d;
      count_q  <= count_d;
      valid_q  <= valid_d;
      ovf_q    <= ovf_d;
    end
  end

  assign bus.value    = value_q;
  assign bus.symCount = count_q;
  assign bus.valid    = valid_q;
  assign bus.overflow = ovf_q;
  assign bus.busy     = (state_q != StIdle);

endmodule

// File: tb/tb_multireceive.sv
// Randomized scoreboard bench for multireceive with a frame/gap-level reference model.
module tb_multireceive;

  localparam int unsigned SyncStages = 2;
  localparam int unsigned MinHigh    = 4;
  localparam int unsigned IdleCycles = 16;
  localparam int unsigned MaxSymsTb  = 11;
  localparam int unsigned Latency    = IdleCycles + SyncStages + 1;

  logic hwclk  = 1'b0;
  logic resetN = 1'b0;
  always #5 hwclk = ~hwclk;

  multireceive_if bus ();

  multireceive #(
    .SYNC_STAGES (SyncStages),
    .MIN_HIGH    (MinHigh),
    .IDLE_CYCLES (IdleCycles),
    .MAX_SYMS    (MaxSymsTb)
  ) dut (
    .hwclk  (hwclk),
    .resetN (resetN),
    .bus    (bus)
  );

  typedef struct {
    logic [31:0] value;
    int          count;
  } frame_t;

  frame_t      exp_q[$];
  int          checks = 0;
  int          passes = 0;
  int          cyc = 0;
  int          last_fall = 0;

  // Reference model: a frame is the list of strobes lasting >= MinHigh cycles,
  // closed once the raw strobe has been low for IdleCycles consecutive cycles.
  bit          open = 1'b0;
  logic [31:0] m_val = '0;
  int          m_n = 0;
  int          low_run = 0;
  logic [31:0] last_value = '0;
  int          last_count = 0;
  bit          exp_ovf = 1'b0;

  always @(posedge hwclk) cyc <= cyc + 1;

  function automatic void check(string name, longint act, longint req);
    checks++;
    if (act == req) passes++;
    else $display("FAIL %s: actual %0d required %0d (t=%0t)", name, act, req, $time);
  endfunction

  function automatic void close_frame();
    if (!open) return;
    if (m_n <= int'(MaxSymsTb)) begin
      exp_q.push_back('{m_val, m_n});
      last_value = m_val;
      last_count = m_n;
      exp_ovf    = 1'b0;
    end else begin
      exp_ovf = 1'b1;
    end
    open = 1'b0;
  endfunction

  // Monitor: pop the expected frame whenever the DUT pulses valid.
  always @(negedge hwclk) begin
    if (resetN && bus.valid) begin
      if (exp_q.size() == 0) begin
        check("unexpected_valid", bus.valid, 0);
      end else begin
        frame_t f;
        f = exp_q.pop_front();
        check("frame_value", bus.value, f.value);
        check("frame_symcount", bus.symCount, f.count);
        check("frame_overflow", bus.overflow, 0);
        check("frame_latency", cyc - last_fall, Latency);
      end
    end
  end

  // All tasks start and end 1 time unit after a rising edge.
  task automatic idle(int n);
    repeat (n) begin
      @(posedge hwclk);
      #1;
      low_run++;
      if (open && low_run >= int'(IdleCycles)) close_frame();
    end
  endtask

  task automatic drive_sym(logic [2:0] s, int hi, int lo);
    logic [2:0] sv;
    sv = s;
    {bus.in2, bus.in1, bus.in0} = sv;
    bus.controlIn = 1'b1;
    low_run = 0;
    if (hi >= int'(MinHigh)) begin
      if (!open) begin
        open  = 1'b1;
        m_val = '0;
        m_n   = 0;
      end
      m_val = (m_val << 3) | {29'b0, sv};
      m_n++;
    end
    repeat (hi) @(posedge hwclk);
    #1;
    bus.controlIn = 1'b0;
    last_fall = cyc;
    idle(lo);
  endtask

  task automatic do_reset();
    bus.controlIn = 1'b0;
    resetN = 1'b0;
    repeat (3) @(posedge hwclk);
    #1;
    resetN     = 1'b1;
    open       = 1'b0;
    low_run    = 0;
    last_value = '0;
    last_count = 0;
    exp_ovf    = 1'b0;
  endtask

  task automatic check_reset_outputs(string tag);
    check({tag, "_value"}, bus.value, 0);
    check({tag, "_symcount"}, bus.symCount, 0);
    check({tag, "_valid"}, bus.valid, 0);
    check({tag, "_overflow"}, bus.overflow, 0);
    check({tag, "_busy"}, bus.busy, 0);
  endtask

  task automatic settle_and_check(string tag);
    idle(IdleCycles + 6);
    check({tag, "_overflow"}, bus.overflow, exp_ovf);
    check({tag, "_held_value"}, bus.value, last_value);
    check({tag, "_held_count"}, bus.symCount, last_count);
    check({tag, "_busy_idle"}, bus.busy, 0);
  endtask

  initial begin
    logic [31:0] word;
    bus.in0 = 1'b0;
    bus.in1 = 1'b0;
    bus.in2 = 1'b0;
    bus.controlIn = 1'b0;
    @(posedge hwclk);
    #1;
    do_reset();
    check_reset_outputs("reset");

    // Full 11-symbol frame carrying 555116.
    word = 32'd555116;
    for (int i = 0; i < 11; i++) begin
      drive_sym(3'((word >> (3 * (10 - i))) & 32'd7), 10, 10);
      if (i == 0) check("busy_in_frame", bus.busy, 1);
    end
    settle_and_check("full_frame");

    // Single keypad digit.
    drive_sym(3'b000, 10, 10);
    drive_sym(3'b111, 10, 10);
    settle_and_check("single_key");

    // Glitch shorter than MinHigh.
    drive_sym(3'b101, int'(MinHigh) - 1, 5);
    check("glitch_busy", bus.busy, 0);
    settle_and_check("glitch");

    // Overflow frame, then a short frame that clears it.
    for (int i = 0; i < 12; i++) drive_sym(3'($urandom_range(0, 7)), 6, 8);
    settle_and_check("overflow");
    drive_sym(3'b010, 6, 8);
    drive_sym(3'b001, 6, 8);
    settle_and_check("overflow_clear");

    // Reset mid-frame after 4 symbols.
    for (int i = 0; i < 4; i++) drive_sym(3'($urandom_range(0, 7)), 6, 6);
    do_reset();
    check_reset_outputs("midframe_reset");
    settle_and_check("after_reset_idle");
    for (int i = 0; i < 3; i++) drive_sym(3'($urandom_range(0, 7)), 6, 6);
    settle_and_check("after_reset_frame");

    // Timeout boundary: 15-cycle gap keeps one frame, 17-cycle gap splits it.
    drive_sym(3'd3, 6, int'(IdleCycles) - 1);
    drive_sym(3'd5, 6, 4);
    settle_and_check("gap_short");
    drive_sym(3'd2, 6, int'(IdleCycles) + 1);
    drive_sym(3'd6, 6, 4);
    settle_and_check("gap_long");

    // Random frames with occasional glitches.
    for (int f = 0; f < 20; f++) begin
      int n;
      n = $urandom_range(1, 13);
      for (int k = 0; k < n; k++) begin
        if ($urandom_range(0, 3) == 0)
          drive_sym(3'($urandom_range(0, 7)), $urandom_range(1, MinHigh - 1), $urandom_range(1, 5));
        drive_sym(3'($urandom_range(0, 7)), $urandom_range(MinHigh, 8), $urandom_range(1, 15));
      end
      settle_and_check("random");
    end

    check("queue_drained", exp_q.size(), 0);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
